rv32i_hazard_ctrl: RTL
======================

RV32I_HAZARD_CTRL -- requirements
Module: rv32i_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_ON_WAIT, default 1'b1: a taken branch arriving during a memory wait is held pending and flushed on exit.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- ex_rs1_addr_i, ex_rs2_addr_i  in  5  EX-stage source registers
- id_rs1_addr_i, id_rs2_addr_i  in  5  ID-stage source registers
- id_rs1_used_i, id_rs2_used_i  in  1  ID operand actually read
- ex_rd_addr_i  in  5  EX destination
- ex_reg_write_i, ex_mem_read_i  in  1  EX writes rd / EX is a load
- mem_rd_addr_i, mem_reg_write_i  in  5 / 1  MEM destination and write enable
- wb_rd_addr_i, wb_reg_write_i  in  5 / 1  WB destination and write enable
- ex_branch_taken_i  in  1  EX redirect
- mem_busy_i  in  1  data memory not ready
- fwd_rs1_sel_o, fwd_rs2_sel_o  out  2  forwarding_sel_e
- pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  out  1  hold stage registers
- if_id_flush_o, id_ex_flush_o  out  1  insert bubble
- stall_cycles_o, flush_count_o  out  32  performance counters

Function
REQ-003 fwd_rsN_sel_o SHALL be FORWARD_FROM_MEM when mem_reg_write_i is set, mem_rd_addr_i is nonzero and mem_rd_addr_i equals ex_rsN_addr_i.
REQ-004 Otherwise fwd_rsN_sel_o SHALL be FORWARD_FROM_WB on the same match against wb_rd_addr_i and wb_reg_write_i; else FORWARD_NONE. MEM SHALL have priority over WB, and x0 SHALL never forward.
REQ-005 load_use SHALL be asserted when ex_mem_read_i and ex_reg_write_i are set, ex_rd_addr_i is nonzero, and ex_rd_addr_i matches an ID source whose _used_i is set.
REQ-006 The FSM states SHALL be S_RUN, S_LOAD_STALL and S_MEM_WAIT; all outputs SHALL be combinational from inputs and registered state.
REQ-007 S_RUN decisions SHALL be evaluated in this priority order:
- mem_busy_i: assert all four stalls, go to S_MEM_WAIT.
- else ex_branch_taken_i: assert both flushes, stay in S_RUN.
- else load_use: assert pc_stall_o and if_id_stall_o plus id_ex_flush_o, go to S_LOAD_STALL.
REQ-008 S_LOAD_STALL SHALL last exactly one cycle with no stalls asserted, then return to S_RUN. Branch and mem_busy_i SHALL be handled as in S_RUN in that cycle, and load_use SHALL be ignored in that cycle.
REQ-009 S_MEM_WAIT behaviour:
- While mem_busy_i is high, assert all four stalls and no flush.
- On the first cycle with mem_busy_i low, deassert stalls and return to S_RUN.
REQ-010 With FLUSH_ON_WAIT=1, ex_branch_taken_i seen in S_MEM_WAIT SHALL set a pending bit. The exit cycle SHALL assert both flushes and clear the bit.
REQ-011 With FLUSH_ON_WAIT=0, ex_branch_taken_i SHALL be sampled only in the exit cycle.
REQ-012 Flush and stall of the same register SHALL never be asserted together; for the ID/EX register, flush SHALL win.

Reset
REQ-013 Asserting rst_ni low at any time, including mid-stall, SHALL force:
- state to S_RUN and the pending bit clear;
- every stall and flush output to 0;
- both fwd selects to FORWARD_NONE;
- both counters to 0.
REQ-014 The first cycle after reset release SHALL behave as S_RUN.

Configuration
REQ-015 With macro RV32I_HAZARD_PERF_EN defined:
- stall_cycles_o SHALL count cycles with pc_stall_o high.
- flush_count_o SHALL count cycles with if_id_flush_o high.
- Both counters SHALL wrap modulo 2^32.
REQ-016 Without RV32I_HAZARD_PERF_EN, both ports SHALL remain present and tied to 0, with no counter flops.

Structure
REQ-017 forwarding_sel_e SHALL come from the shared control package rv32i_control_pkg.
REQ-018 The FSM state enum hazard_state_e SHALL be added to rv32i_control_pkg.
REQ-019 The forwarding compare SHALL be sub-module rv32i_fwd_unit, instantiated once per operand.

Verification
REQ-020 Forwarding priority:
- MEM rd=5 writing, WB rd=5 writing, ex_rs1=5 -> fwd_rs1_sel_o=MEM.
- Same with MEM write off -> WB.
- rd=0 in both -> NONE.
REQ-021 Load-use:
- EX load rd=3, ID rs2=3 used -> one cycle of pc/if_id stall plus id_ex_flush, then S_RUN with no stall.
- Same with id_rs2_used_i=0 -> no stall.
REQ-022 Memory wait: mem_busy_i high 4 cycles -> four stalls high for exactly 4 cycles, released on cycle 5.
REQ-023 Pending branch: mem_busy_i high 3 cycles with a branch pulse in cycle 2, FLUSH_ON_WAIT=1 -> both flushes in exit cycle 4.
REQ-024 Simultaneous events: branch and load_use in the same S_RUN cycle -> flushes only, no stall.
REQ-025 Mid-wait reset and counters:
- rst_ni dropped during S_MEM_WAIT -> all outputs 0 immediately.
- With RV32I_HAZARD_PERF_EN, after REQ-022 stall_cycles_o=4.

Source files
------------

// File: rtl/rv32i_control_pkg.sv
// Shared pipeline-control types: forwarding mux selects and the hazard controller FSM states.
package rv32i_control_pkg;

  typedef enum logic [1:0] {
    FORWARD_NONE     = 2'b00,
    FORWARD_FROM_WB  = 2'b01,
    FORWARD_FROM_MEM = 2'b10
  } forwarding_sel_e;

  typedef enum logic [1:0] {
    S_RUN        = 2'b00,
    S_LOAD_STALL = 2'b01,
    S_MEM_WAIT   = 2'b10
  } hazard_state_e;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic reg_match(input logic [4:0] rd, input logic we, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/rv32i_fwd_unit.sv
// Operand forwarding select for one EX source register; MEM result beats WB result.
module rv32i_fwd_unit
  import rv32i_control_pkg::*;
(
  input  logic [4:0]      rs_addr_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_reg_write_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            wb_reg_write_i,
  output forwarding_sel_e fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FORWARD_NONE;
    if (reg_match(mem_rd_addr_i, mem_reg_write_i, rs_addr_i)) begin
      fwd_sel_o = FORWARD_FROM_MEM;
    end else if (reg_match(wb_rd_addr_i, wb_reg_write_i, rs_addr_i)) begin
      fwd_sel_o = FORWARD_FROM_WB;
    end
  end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// RV32I pipeline hazard controller: forwarding, load-use stall, memory-wait stall, branch flush.
// Define RV32I_HAZARD_PERF_EN to enable the stall/flush performance counters.
module rv32i_hazard_ctrl
  import rv32i_control_pkg::*;
#(
  parameter bit FLUSH_ON_WAIT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      ex_rs1_addr_i,
  input  logic [4:0]      ex_rs2_addr_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_reg_write_i,
  input  logic            ex_mem_read_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_reg_write_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            wb_reg_write_i,
  input  logic            ex_branch_taken_i,
  input  logic            mem_busy_i,
  output forwarding_sel_e fwd_rs1_sel_o,
  output forwarding_sel_e fwd_rs2_sel_o,
  output logic            pc_stall_o,
  output logic            if_id_stall_o,
  output logic            id_ex_stall_o,
  output logic            ex_mem_stall_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic [31:0]     stall_cycles_o,
  output logic [31:0]     flush_count_o
);

  hazard_state_e   state_q, state_d;
  logic            pend_q, pend_d;
  logic            load_use;
  logic            pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic            if_id_flush, id_ex_flush;
  forwarding_sel_e fwd_rs1, fwd_rs2;

  rv32i_fwd_unit u_fwd_rs1 (
    .rs_addr_i       (ex_rs1_addr_i),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_reg_write_i (mem_reg_write_i),
    .wb_rd_addr_i    (wb_rd_addr_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .fwd_sel_o       (fwd_rs1)
  );

  rv32i_fwd_unit u_fwd_rs2 (
    .rs_addr_i       (ex_rs2_addr_i),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_reg_write_i (mem_reg_write_i),
    .wb_rd_addr_i    (wb_rd_addr_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .fwd_sel_o       (fwd_rs2)
  );

  assign load_use = ex_mem_read_i && ex_reg_write_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

  always_comb begin
    state_d      = state_q;
    pend_d       = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    case (state_q)
      S_RUN, S_LOAD_STALL: begin
        if (mem_busy_i) begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'b1111;
          state_d = S_MEM_WAIT;
        end else if (ex_branch_taken_i) begin
          {if_id_flush, id_ex_flush} = 2'b11;
          state_d = S_RUN;
        end else if (load_use && (state_q == S_RUN)) begin
          // ID/EX gets a bubble rather than a hold so the load can advance.
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = S_LOAD_STALL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        if (mem_busy_i) begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'b1111;
          pend_d = pend_q | (FLUSH_ON_WAIT & ex_branch_taken_i);
        end else begin
          if (pend_q || ex_branch_taken_i) begin
            {if_id_flush, id_ex_flush} = 2'b11;
          end
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs are forced quiet while reset is held, even with live pipeline inputs.
  assign fwd_rs1_sel_o  = rst_ni ? fwd_rs1 : FORWARD_NONE;
  assign fwd_rs2_sel_o  = rst_ni ? fwd_rs2 : FORWARD_NONE;
  assign pc_stall_o     = rst_ni & pc_stall;
  assign if_id_stall_o  = rst_ni & if_id_stall;
  assign id_ex_stall_o  = rst_ni & id_ex_stall;
  assign ex_mem_stall_o = rst_ni & ex_mem_stall;
  assign if_id_flush_o  = rst_ni & if_id_flush;
  assign id_ex_flush_o  = rst_ni & id_ex_flush;

`ifdef RV32I_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (pc_stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_id_flush_o) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif

endmodule
